rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Shares the register file's single write port between several writeback requesters, such as the ALU, load unit and multiply/divide unit. Each requester presents a write (address, data) under a valid/ready handshake. The block grants at most one requester per cycle using round-robin. It drives the register file write port from a registered stage, so a write lands one cycle after acceptance. Accepted writes to register 0 are discarded.

## Interface
Parameters:
- N_REQ, 3, number of writeback requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  requester i has a write pending
- req_ready  out  N_REQ  requester i's write accepted this cycle (one-hot or zero)
- req_addr  in  N_REQ x ADDR_W  destination register per requester
- req_data  in  N_REQ x DATA_W  write data per requester
- rf_wenable  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- grant_id  out  $clog2(N_REQ)  index of the requester whose write is on the rf_* outputs
- stall_cnt  out  16  saturating count of cycles with at least one valid request not granted

## Operation
- Handshake:
  - A write is accepted when req_valid[i] && req_ready[i].
  - Requester i holds req_valid[i], req_addr[i] and req_data[i] stable until it is accepted.
  - req_ready depends combinationally on req_valid and the priority pointer.
- Arbitration:
  - The rotating pointer ptr starts at 0.
  - The granted requester is the first i with req_valid[i], searching ptr, ptr+1, ... modulo N_REQ.
  - After a grant to i, ptr becomes (i+1) mod N_REQ.
  - With no valid request, ptr is unchanged and req_ready is all zero.
- Output stage:
  - On acceptance, rf_waddr, rf_wdata and grant_id are loaded at the next edge.
  - rf_wenable is set to (req_addr != 0).
  - With no acceptance, rf_wenable is 0 next cycle and rf_waddr, rf_wdata and grant_id hold their values.
- Register 0: the write is accepted (ready asserted, ptr advances) but never enables a write.
- Same address from two requesters in one cycle: only the winner is written. The loser is written in a later cycle, so the last write wins in grant order.
- stall_cnt increments in each cycle where req_valid is non-zero and req_valid & ~req_ready is non-zero. It saturates at 0xFFFF.
- Reset values: ptr=0, rf_wenable=0, rf_waddr=0, rf_wdata=0, grant_id=0, stall_cnt=0. While rst is high, req_ready is all zero.

## Timing
- Latency: accepted in cycle T means rf_wenable=1 with that address and data in cycle T+1. The write is visible in the register file after the edge ending T+1.
- Throughput: one write per cycle. Back-to-back grants to the same requester are allowed only when no other requester is valid.
- Fairness: with all N_REQ valid continuously, each requester is granted exactly once every N_REQ cycles.
- Reset mid-operation: a write accepted in the cycle rst rises is dropped, and rf_wenable=0 in the following cycle. Requesters see no ready during reset and keep their requests pending.
- No combinational path from any req_* input to any rf_* output.

## Configuration
- RF_WB_FIXED_PRIO_EN defined:
  - Fixed priority is used; requester 0 is highest, N_REQ-1 is lowest.
  - ptr is removed. All other behaviour is unchanged.
- RF_WB_FIXED_PRIO_EN undefined: round-robin as described above (default).

## Structure
- Package rf_pkg holds:
  - types reg_addr_t (ADDR_W bits) and reg_data_t (DATA_W bits)
  - the constant RF_ZERO_ADDR = 0
  - the default N_REQ
- Sub-module rr_arbiter: purely combinational. It takes req and ptr, and produces a one-hot grant plus the grant index. The macro selects between the rotating search and the fixed-priority search inside this sub-module.
- The top level holds ptr, the output registers and stall_cnt.

## Test plan
- Single requester: req 1 with addr 5, data 0xDEADBEEF held for one cycle -> req_ready=3'b010 in cycle T; rf_wenable=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_id=1 in T+1.
- All three valid for 6 cycles from reset -> grants 0,1,2,0,1,2 and stall_cnt=6 (under RF_WB_FIXED_PRIO_EN: grants 0,0,0,0,0,0).
- Requester 2 writes addr 0, data 0x1234 -> req_ready[2]=1 and ptr advances to 0; rf_wenable=0 in the next cycle.
- Req 0 and req 1 both target addr 7 with data 0xA and 0xB from ptr=0 -> rf_wdata=0xA in T+1 and 0xB in T+2; the final register value is 0xB.
- rst asserted in the cycle req 0 is accepted -> rf_wenable=0 next cycle, all outputs zero, req_ready=0 during reset; the request is granted in the first cycle after rst falls.
- stall_cnt preloaded near saturation by holding two requesters valid for 70000 cycles -> stall_cnt reads 0xFFFF and stays there.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

  localparam int RF_N_REQ  = 3;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: rotating search from ptr, or fixed
// priority (index 0 highest) when RF_WB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N     = RF_N_REQ,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
`ifndef RF_WB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] sel;
  int               idx;

  // Walk candidates from lowest to highest priority so the
  // highest-priority valid request is the last one written.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    sel     = '0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
`ifdef RF_WB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(ptr) + k) % N;
`endif
      sel = IDX_W'(idx);
      if (req[sel]) begin
        gnt      = '0;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with a registered output stage.
// Define RF_WB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ  = RF_N_REQ,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
  output logic                          rf_wenable,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic [15:0]                   stall_cnt
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             accept;
  logic             stalled;

`ifndef RF_WB_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr;
`endif

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req_valid),
`ifndef RF_WB_FIXED_PRIO_EN
    .ptr     (ptr),
`endif
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = rst ? '0 : gnt;
  assign accept    = |req_ready;
  assign stalled   = |(req_valid & ~req_ready);

`ifndef RF_WB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  // Writes to x0 are still accepted; only the enable is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wenable <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      grant_id   <= '0;
    end else begin
      rf_wenable <= accept &&
                    (req_addr[gnt_idx] != ADDR_W'(RF_ZERO_ADDR));
      if (accept) begin
        rf_waddr <= req_addr[gnt_idx];
        rf_wdata <= req_data[gnt_idx];
        grant_id <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stalled && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
